// File: rtl/design_variables.sv
// ---------------------------------------------------------------------------
// design_variables
//   Shared widths and types for the alignment result path.
//   SCORE_WIDTH / ROW_BITS_WIDTH / COL_BITS_WIDTH : default field widths of the
//     running-max register bank.
//   report_state_t : state encoding of the result reporter.
//   num_beats()    : ceiling division giving the bus beats needed for a word.
// ---------------------------------------------------------------------------
package design_variables;

  localparam int SCORE_WIDTH    = 8;
  localparam int ROW_BITS_WIDTH = 5;
  localparam int COL_BITS_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } report_state_t;

  function automatic int num_beats(input int res_w, input int out_w);
    return (res_w + out_w - 1) / out_w;
  endfunction

endpackage

// File: rtl/max_result_reporter.sv
// ---------------------------------------------------------------------------
// max_result_reporter
//   Snapshots {max_score,max_row,max_col} on start_report and streams the
//   packed word out over a narrow valid/ready bus, least significant beat
//   first, marking the final beat and pulsing report_done afterwards.
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : synchronous active-low reset
//   start_report  : 1-cycle pulse, max bank is final
//   max_score     : running max score
//   max_row       : row of the max
//   max_col       : column of the max
//   clr_flags     : clears the sticky dropped_start flag
//   out_ready     : sink ready
//   out_valid     : beat valid
//   out_data      : beat payload
//   out_last      : final beat of the result
//   no_match      : captured score was zero (held with the result)
//   busy          : reporter not idle
//   report_done   : 1-cycle pulse after the last beat is accepted
//   dropped_start : sticky, a start arrived while busy
// ---------------------------------------------------------------------------
module max_result_reporter
  import design_variables::*;
#(
  parameter int SCORE_W   = SCORE_WIDTH,
  parameter int ROW_W     = ROW_BITS_WIDTH,
  parameter int COL_W     = COL_BITS_WIDTH,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_report,
  input  logic [SCORE_W-1:0]   max_score,
  input  logic [ROW_W-1:0]     max_row,
  input  logic [COL_W-1:0]     max_col,
  input  logic                 clr_flags,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 no_match,
  output logic                 busy,
  output logic                 report_done,
  output logic                 dropped_start
);

  localparam int RES_W     = SCORE_W + ROW_W + COL_W;
  localparam int NUM_BEATS = num_beats(RES_W, OUT_WIDTH);
  localparam int PAD_W     = NUM_BEATS * OUT_WIDTH;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

  report_state_t      state_q;
  logic [PAD_W-1:0]   shift_q;
  logic [PAD_W-1:0]   word_d;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [CNT_W-1:0]   beat_cnt_d;
  logic               out_valid_q;
  logic               out_last_q;
  logic               no_match_q;
  logic               busy_q;
  logic               report_done_q;
  logic               dropped_q;
  logic               hs;

  // Column in the LSBs, zero padding above the score up to a whole beat.
  always_comb begin
    word_d            = '0;
    word_d[RES_W-1:0] = {max_score, max_row, max_col};
  end

  assign beat_cnt_d = beat_cnt_q + CNT_W'(1);
  assign hs         = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      beat_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      no_match_q    <= 1'b0;
      busy_q        <= 1'b0;
      report_done_q <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      report_done_q <= 1'b0;

      // A start that cannot be honoured sets the flag; setting beats clearing.
      if (start_report && (state_q != IDLE)) begin
        dropped_q <= 1'b1;
      end else if (clr_flags) begin
        dropped_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start_report) begin
            state_q     <= SEND;
            shift_q     <= word_d;
            beat_cnt_q  <= '0;
            no_match_q  <= (max_score == '0);
            out_valid_q <= 1'b1;
            out_last_q  <= (NUM_BEATS == 1);
            busy_q      <= 1'b1;
          end
        end

        SEND: begin
          // Without a handshake every output register simply holds.
          if (hs) begin
            if (out_last_q) begin
              state_q       <= DONE;
              out_valid_q   <= 1'b0;
              out_last_q    <= 1'b0;
              report_done_q <= 1'b1;
            end else begin
              shift_q    <= shift_q >> OUT_WIDTH;
              beat_cnt_q <= beat_cnt_d;
              out_last_q <= (beat_cnt_d == LAST_CNT);
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = shift_q[OUT_WIDTH-1:0];
  assign out_last      = out_last_q;
  assign no_match      = no_match_q;
  assign busy          = busy_q;
  assign report_done   = report_done_q;
  assign dropped_start = dropped_q;

endmodule

// File: tb/tb_max_result_reporter.sv
module tb_max_result_reporter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_report = 1'b0;
  logic        clr_flags = 1'b0;
  logic [7:0]  max_score = '0;
  logic [4:0]  max_row = '0;
  logic [4:0]  max_col = '0;
  logic        rdy8 = 1'b1;
  logic        rdy32 = 1'b1;

  logic        v8, l8, nm8, b8, rd8, ds8;
  logic [7:0]  d8;
  logic        v32, l32, nm32, b32, rd32, ds32;
  logic [31:0] d32;

  max_result_reporter #(.SCORE_W(8), .ROW_W(5), .COL_W(5), .OUT_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_report(start_report),
    .max_score(max_score), .max_row(max_row), .max_col(max_col),
    .clr_flags(clr_flags), .out_ready(rdy8),
    .out_valid(v8), .out_data(d8), .out_last(l8), .no_match(nm8),
    .busy(b8), .report_done(rd8), .dropped_start(ds8)
  );

  max_result_reporter #(.SCORE_W(8), .ROW_W(5), .COL_W(5), .OUT_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_report(start_report),
    .max_score(max_score), .max_row(max_row), .max_col(max_col),
    .clr_flags(clr_flags), .out_ready(rdy32),
    .out_valid(v32), .out_data(d32), .out_last(l32), .no_match(nm32),
    .busy(b32), .report_done(rd32), .dropped_start(ds32)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one pending transaction per DUT, described as the packed
  // integer word plus the number of beats still to be accepted.
  int          rem     [2];
  int          idx     [2];
  bit          done_now[2];
  bit          nm_e    [2];
  bit          drop_e  [2];
  longint      word_e  [2];
  int          done_cnt[2];
  logic [7:0]  acc8[$];
  logic [31:0] acc32[$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      rem[d] = 0; idx[d] = 0; done_now[d] = 0; nm_e[d] = 0;
      drop_e[d] = 0; word_e[d] = 0; done_cnt[d] = 0;
    end
  end

  always @(negedge clk) begin
    logic [31:0] od  [2];
    bit          ov  [2];
    bit          ol  [2];
    bit          onm [2];
    bit          ob  [2];
    bit          ord [2];
    bit          ods [2];
    bit          rdy [2];
    int          w;
    longint      expb;
    bit          busy_m;
    string       p;
    od[0] = {24'h0, d8}; od[1] = d32;
    ov[0] = v8;   ov[1] = v32;
    ol[0] = l8;   ol[1] = l32;
    onm[0] = nm8; onm[1] = nm32;
    ob[0] = b8;   ob[1] = b32;
    ord[0] = rd8; ord[1] = rd32;
    ods[0] = ds8; ods[1] = ds32;
    rdy[0] = rdy8; rdy[1] = rdy32;
    for (int d = 0; d < 2; d++) begin
      w = (d == 0) ? 8 : 32;
      p = (d == 0) ? "w8_" : "w32_";
      check({p, "valid"}, 64'(ov[d]), 64'(rem[d] > 0));
      check({p, "busy"}, 64'(ob[d]), 64'((rem[d] > 0) || done_now[d]));
      check({p, "done"}, 64'(ord[d]), 64'(done_now[d]));
      check({p, "no_match"}, 64'(onm[d]), 64'(nm_e[d]));
      check({p, "dropped"}, 64'(ods[d]), 64'(drop_e[d]));
      if (rem[d] > 0) begin
        expb = (word_e[d] / (64'd1 << (w * idx[d]))) % (64'd1 << w);
        check({p, "data"}, 64'(od[d]), 64'(expb));
        check({p, "last"}, 64'(ol[d]), 64'(rem[d] == 1));
      end
      if (ov[d] && rdy[d]) begin
        if (d == 0) acc8.push_back(od[0][7:0]);
        else        acc32.push_back(od[1]);
      end
      if (ord[d]) done_cnt[d]++;

      if (!rst_n) begin
        rem[d] = 0; idx[d] = 0; done_now[d] = 0; nm_e[d] = 0; drop_e[d] = 0;
      end else begin
        busy_m = (rem[d] > 0) || done_now[d];
        if (start_report && busy_m) drop_e[d] = 1;
        else if (clr_flags)         drop_e[d] = 0;
        if (done_now[d]) begin
          done_now[d] = 0;
        end else if (rem[d] > 0) begin
          if (rdy[d]) begin
            rem[d]--;
            idx[d]++;
            if (rem[d] == 0) done_now[d] = 1;
          end
        end else if (start_report) begin
          word_e[d] = longint'(max_score) * 1024 + longint'(max_row) * 32 + longint'(max_col);
          rem[d]    = (18 + w - 1) / w;
          idx[d]    = 0;
          nm_e[d]   = (max_score == 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] s, input logic [4:0] r, input logic [4:0] c);
    max_score    = s;
    max_row      = r;
    max_col      = c;
    start_report = 1'b1;
    tick();
    start_report = 1'b0;
  endtask

  int d0;

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_valid", 64'(v8), 64'd0);
    check("rst_last", 64'(l8), 64'd0);
    check("rst_busy", 64'(b8), 64'd0);
    check("rst_done", 64'(rd8), 64'd0);
    check("rst_drop", 64'(ds8), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: basic three-beat transfer with ready high
    acc8.delete(); acc32.delete(); d0 = done_cnt[0];
    rdy8 = 1'b1; rdy32 = 1'b1;
    send(8'hA5, 5'h13, 5'h0C);
    check("t1_nm", 64'(nm8), 64'd0);
    repeat (6) tick();
    check("t1_nbeats", 64'(acc8.size()), 64'd3);
    if (acc8.size() == 3) begin
      check("t1_b0", 64'(acc8[0]), 64'h6C);
      check("t1_b1", 64'(acc8[1]), 64'h96);
      check("t1_b2", 64'(acc8[2]), 64'h02);
    end
    check("t1_ndone", 64'(done_cnt[0] - d0), 64'd1);
    check("t6_nbeats", 64'(acc32.size()), 64'd1);
    if (acc32.size() == 1) check("t6_beat", 64'(acc32[0]), 64'h0002966C);

    // 2: backpressure on beat 1
    acc8.delete();
    send(8'hA5, 5'h13, 5'h0C);
    tick();
    rdy8 = 1'b0;
    repeat (4) tick();
    check("t2_hold_valid", 64'(v8), 64'd1);
    check("t2_hold_data", 64'(d8), 64'h96);
    rdy8 = 1'b1;
    repeat (5) tick();
    check("t2_nbeats", 64'(acc8.size()), 64'd3);
    if (acc8.size() == 3) check("t2_b1", 64'(acc8[1]), 64'h96);

    // 3: zero score
    acc8.delete(); d0 = done_cnt[0];
    send(8'h00, 5'h00, 5'h00);
    check("t3_nm", 64'(nm8), 64'd1);
    repeat (6) tick();
    check("t3_nbeats", 64'(acc8.size()), 64'd3);
    check("t3_ndone", 64'(done_cnt[0] - d0), 64'd1);

    // 4: start while sending is dropped
    acc8.delete();
    send(8'hA5, 5'h13, 5'h0C);
    send(8'h11, 5'h01, 5'h02);
    check("t4_drop", 64'(ds8), 64'd1);
    repeat (6) tick();
    check("t4_drop_held", 64'(ds8), 64'd1);
    if (acc8.size() == 3) check("t4_b0", 64'(acc8[0]), 64'h6C);
    else check("t4_nbeats", 64'(acc8.size()), 64'd3);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t4_drop_clr", 64'(ds8), 64'd0);

    // 5: reset after beat 0 accepted
    send(8'hA5, 5'h13, 5'h0C);
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_valid", 64'(v8), 64'd0);
    check("t5_busy", 64'(b8), 64'd0);
    rst_n = 1'b1;
    acc8.delete();
    send(8'h3C, 5'h1F, 5'h01);
    repeat (6) tick();
    check("t5_nbeats", 64'(acc8.size()), 64'd3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      max_score    = 8'($urandom);
      max_row      = 5'($urandom);
      max_col      = 5'($urandom);
      start_report = ($urandom_range(0, 5) == 0);
      rdy8         = ($urandom_range(0, 3) != 0);
      rdy32        = ($urandom_range(0, 3) != 0);
      clr_flags    = ($urandom_range(0, 19) == 0);
      rst_n        = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) max_score = 8'h00;
      tick();
    end
    start_report = 1'b0; clr_flags = 1'b0; rst_n = 1'b1;
    rdy8 = 1'b1; rdy32 = 1'b1;
    repeat (10) tick();
    check("end_idle", 64'(b8), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
